// File: rtl/led_seq_pkg.sv
// Shared types for the LED pattern sequencer: pattern modes, FSM states and
// the per-mode pass length.
package led_seq_pkg;

  typedef enum logic [1:0] {
    FILL     = 2'b00,
    CHASE    = 2'b01,
    PINGPONG = 2'b10,
    BLINK    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_e;

  // Number of steps in one full pass of a pattern over n LEDs.
  function automatic int unsigned steps_per_pass(mode_e mode, int unsigned n);
    case (mode)
      FILL, CHASE: return n;
      PINGPONG:    return 2 * n - 2;
      default:     return 2;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_decode.sv
// Combinational step-to-LED mapping; each lane decides independently whether
// it is lit for the latched mode and current step.
module led_pattern_decode
  import led_seq_pkg::*;
#(
  parameter int NUM_LEDS = 18,
  parameter int SW       = $clog2(2 * NUM_LEDS)
) (
  input  mode_e               i_mode,
  input  logic [SW-1:0]       i_step,
  input  logic                i_active,
  output logic [NUM_LEDS-1:0] o_led
);

  localparam logic [SW-1:0] PP_TOP = SW'(2 * NUM_LEDS - 2);
  localparam logic [SW-1:0] N_SW   = SW'(NUM_LEDS);

  // Second half of a ping-pong pass walks back down from the top LED.
  logic [SW-1:0] w_pp_idx;
  assign w_pp_idx = (i_step < N_SW) ? i_step : PP_TOP - i_step;

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_lane
    localparam logic [SW-1:0] IDX = SW'(g);
    assign o_led[g] = i_active && (
      (i_mode == FILL     && IDX <= i_step)   ||
      (i_mode == CHASE    && IDX == i_step)   ||
      (i_mode == PINGPONG && IDX == w_pp_idx) ||
      (i_mode == BLINK    && i_step == '0));
  end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: tick-driven step counter with programmable dwell,
// run/pause/idle control and mode/dwell latched only at entry and pass wrap.
module led_pattern_seq
  import led_seq_pkg::*;
#(
  parameter  int NUM_LEDS = 18,
  parameter  int DWELL_W  = 4,
  localparam int SW       = $clog2(2 * NUM_LEDS)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                PULSE,
  input  logic                ENABLE,
  input  logic                HOLD,
  input  logic [1:0]          MODE,
  input  logic [DWELL_W-1:0]  DWELL,
  output logic [NUM_LEDS-1:0] LED,
  output logic [SW-1:0]       STEP,
  output logic [1:0]          STATE,
  output logic                WRAP
);

  state_e             r_state, w_state;
  logic [SW-1:0]      r_step,  w_step;
  logic [DWELL_W-1:0] r_dcnt,  w_dcnt;
  mode_e              r_mode,  w_mode;
  logic [DWELL_W-1:0] r_dwell, w_dwell;
  logic               r_wrap,  w_wrap;
  logic [SW-1:0]      w_last;

  assign w_last = SW'(steps_per_pass(r_mode, NUM_LEDS) - 1);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_step  <= '0;
      r_dcnt  <= '0;
      r_mode  <= FILL;
      r_dwell <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_step  <= w_step;
      r_dcnt  <= w_dcnt;
      r_mode  <= w_mode;
      r_dwell <= w_dwell;
      r_wrap  <= w_wrap;
    end
  end

  always_comb begin
    w_state = r_state;
    w_step  = r_step;
    w_dcnt  = r_dcnt;
    w_mode  = r_mode;
    w_dwell = r_dwell;
    w_wrap  = 1'b0;
    case (r_state)
      IDLE: begin
        w_step = '0;
        w_dcnt = '0;
        // A tick arriving on the entry edge is deliberately dropped.
        if (ENABLE) begin
          w_state = RUN;
          w_mode  = mode_e'(MODE);
          w_dwell = DWELL;
        end
      end
      RUN: begin
        if (!ENABLE) begin
          w_state = IDLE;
          w_step  = '0;
          w_dcnt  = '0;
        end else if (HOLD) begin
          w_state = PAUSE;
        end else if (PULSE) begin
          if (r_dcnt != r_dwell) begin
            w_dcnt = r_dcnt + 1'b1;
          end else begin
            w_dcnt = '0;
            if (r_step == w_last) begin
              w_step  = '0;
              w_wrap  = 1'b1;
              w_mode  = mode_e'(MODE);
              w_dwell = DWELL;
            end else begin
              w_step = r_step + 1'b1;
            end
          end
        end
      end
      PAUSE: begin
        if (!ENABLE) begin
          w_state = IDLE;
          w_step  = '0;
          w_dcnt  = '0;
        end else if (!HOLD) begin
          w_state = RUN;
        end
      end
      default: begin
        w_state = IDLE;
        w_step  = '0;
        w_dcnt  = '0;
      end
    endcase
  end

  led_pattern_decode #(
    .NUM_LEDS (NUM_LEDS),
    .SW       (SW)
  ) u_decode (
    .i_mode   (r_mode),
    .i_step   (r_step),
    .i_active (r_state != IDLE),
    .o_led    (LED)
  );

  assign STEP  = r_step;
  assign STATE = r_state;
  assign WRAP  = r_wrap;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq: vector table, directed corner
// sequences and randomized traffic against a tick-level reference model.
module tb_led_pattern_seq;
  localparam int N  = 18;
  localparam int DW = 4;
  localparam int SW = $clog2(2 * N);

  logic          CLK = 1'b0;
  logic          RESET, PULSE, ENABLE, HOLD;
  logic [1:0]    MODE;
  logic [DW-1:0] DWELL;
  logic [N-1:0]  LED;
  logic [SW-1:0] STEP;
  logic [1:0]    STATE;
  logic          WRAP;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  led_pattern_seq #(.NUM_LEDS(N), .DWELL_W(DW)) dut (
    .CLK(CLK), .RESET(RESET), .PULSE(PULSE), .ENABLE(ENABLE), .HOLD(HOLD),
    .MODE(MODE), .DWELL(DWELL), .LED(LED), .STEP(STEP), .STATE(STATE), .WRAP(WRAP)
  );

  // Reference model: 0 idle, 1 run, 2 pause; ticks-in-step and step index.
  int m_st, m_step, m_dcnt, m_mode, m_dwell;
  bit m_wrap;

  function automatic int pass_len(int md);
    case (md)
      0, 1:    return N;
      2:       return 2 * N - 2;
      default: return 2;
    endcase
  endfunction

  function automatic logic [N-1:0] pat(int md, int s, int st);
    logic [N:0] t;
    t = '0;
    t[0] = 1'b1;
    if (st == 0) return '0;
    case (md)
      0:       t = (t << (s + 1)) - 1'b1;
      1:       t = t << s;
      2:       t = t << ((s < N) ? s : 2 * N - 2 - s);
      default: t = (s == 0) ? '1 : '0;
    endcase
    return t[N-1:0];
  endfunction

  task automatic model_reset();
    m_st = 0; m_step = 0; m_dcnt = 0; m_mode = 0; m_dwell = 0; m_wrap = 0;
  endtask

  task automatic model_tick(input bit en, hold, pulse, input int md, dw);
    m_wrap = 0;
    if (m_st == 0) begin
      m_step = 0; m_dcnt = 0;
      if (en) begin m_st = 1; m_mode = md; m_dwell = dw; end
    end else if (!en) begin
      m_st = 0; m_step = 0; m_dcnt = 0;
    end else if (m_st == 2) begin
      if (!hold) m_st = 1;
    end else if (hold) begin
      m_st = 2;
    end else if (pulse) begin
      if (m_dcnt < m_dwell) m_dcnt++;
      else begin
        m_dcnt = 0;
        m_step++;
        if (m_step == pass_len(m_mode)) begin
          m_step = 0; m_wrap = 1; m_mode = md; m_dwell = dw;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("state", 64'(STATE), 64'(m_st));
    chk("step",  64'(STEP),  64'(m_step));
    chk("led",   64'(LED),   64'(pat(m_mode, m_step, m_st)));
    chk("wrap",  64'(WRAP),  64'(m_wrap));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic cyc(input bit en, hold, pulse, input int md, dw);
    ENABLE = en; HOLD = hold; PULSE = pulse; MODE = md[1:0]; DWELL = dw[DW-1:0];
    @(posedge CLK);
    model_tick(en, hold, pulse, md, dw);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit en, hold, pulse;
    int md, dw;
    logic [1:0] st;
    int step;
    logic [N-1:0] led;
    bit wrap;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int wt, ft, nwrap;
    RESET = 1'b1; PULSE = 0; ENABLE = 0; HOLD = 0; MODE = 0; DWELL = 0;
    #1;
    chk("reset_led",   64'(LED),   64'h0);
    chk("reset_state", 64'(STATE), 64'h0);
    chk("reset_step",  64'(STEP),  64'h0);
    chk("reset_wrap",  64'(WRAP),  64'h0);
    do_reset();

    // Vector table from reset: FILL, DWELL=0, with pause and disable.
    tbl[0] = '{0, 0, 0, 0, 0, 2'd0, 0, 18'h00000, 0};
    tbl[1] = '{1, 0, 1, 0, 0, 2'd1, 0, 18'h00001, 0};
    tbl[2] = '{1, 0, 1, 0, 0, 2'd1, 1, 18'h00003, 0};
    tbl[3] = '{1, 0, 0, 0, 0, 2'd1, 1, 18'h00003, 0};
    tbl[4] = '{1, 0, 1, 3, 9, 2'd1, 2, 18'h00007, 0};
    tbl[5] = '{1, 1, 1, 0, 0, 2'd2, 2, 18'h00007, 0};
    tbl[6] = '{1, 1, 1, 0, 0, 2'd2, 2, 18'h00007, 0};
    tbl[7] = '{1, 0, 1, 0, 0, 2'd1, 2, 18'h00007, 0};
    tbl[8] = '{1, 0, 1, 0, 0, 2'd1, 3, 18'h0000F, 0};
    tbl[9] = '{0, 0, 1, 0, 0, 2'd0, 0, 18'h00000, 0};
    for (int i = 0; i < 10; i++) begin
      ENABLE = tbl[i].en; HOLD = tbl[i].hold; PULSE = tbl[i].pulse;
      MODE = tbl[i].md[1:0]; DWELL = tbl[i].dw[DW-1:0];
      @(posedge CLK);
      model_tick(tbl[i].en, tbl[i].hold, tbl[i].pulse, tbl[i].md, tbl[i].dw);
      #1;
      chk($sformatf("vec%0d_state", i), 64'(STATE), 64'(tbl[i].st));
      chk($sformatf("vec%0d_step", i),  64'(STEP),  64'(tbl[i].step));
      chk($sformatf("vec%0d_led", i),   64'(LED),   64'(tbl[i].led));
      chk($sformatf("vec%0d_wrap", i),  64'(WRAP),  64'(tbl[i].wrap));
    end

    // FILL full pass, one step per tick.
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    nwrap = 0;
    for (int k = 1; k <= 18; k++) begin
      cyc(1, 0, 1, 0, 0);
      if (WRAP) nwrap++;
      if (k == 17) chk("fill_full", 64'(LED), 64'h3FFFF);
      if (k == 18) begin
        chk("fill_wrap_led", 64'(LED), 64'h00001);
        chk("fill_wrap", 64'(WRAP), 64'h1);
      end
    end
    cyc(1, 0, 0, 0, 0);
    chk("fill_wrap_once", 64'(WRAP), 64'h0);
    chk("fill_wrap_count", 64'(nwrap), 64'd1);

    // PINGPONG, DWELL=2, tick every 4th cycle.
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 2, 2);
    wt = 0;
    for (int t = 1; t <= 110 && wt == 0; t++) begin
      cyc(1, 0, 1, 2, 2);
      if (WRAP) wt = t;
      if (t == 51) chk("pp_top", 64'(LED), 64'h20000);
      if (t == 54) chk("pp_back", 64'(LED), 64'h10000);
      repeat (3) cyc(1, 0, 0, 2, 2);
    end
    chk("pp_wrap_tick", 64'(wt), 64'd102);

    // MODE switched mid-pass takes effect only at the wrap.
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    for (int k = 1; k <= 5; k++) cyc(1, 0, 1, 1, 0);
    for (int k = 6; k <= 19; k++) begin
      cyc(1, 0, 1, 3, 0);
      if (k == 6)  chk("relatch_still_chase", 64'(LED), 64'h00040);
      if (k == 17) chk("relatch_chase_top", 64'(LED), 64'h20000);
      if (k == 18) chk("relatch_blink_on", 64'(LED), 64'h3FFFF);
      if (k == 19) chk("relatch_blink_off", 64'(LED), 64'h00000);
    end

    // HOLD at CHASE step 9 with dcnt mid-step.
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 1);
    for (int k = 0; k < 19; k++) cyc(1, 0, 1, 1, 1);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 1, 1, 1, 1);
      chk("hold_state", 64'(STATE), 64'h2);
      chk("hold_led", 64'(LED), 64'h00200);
    end
    cyc(1, 0, 1, 1, 1);
    chk("hold_release_step", 64'(STEP), 64'd9);
    cyc(1, 0, 1, 1, 1);
    chk("hold_dcnt_kept", 64'(STEP), 64'd10);

    // ENABLE low on the wrap edge, then re-enable with maximum dwell.
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 3, 0);
    cyc(1, 0, 1, 3, 0);
    cyc(0, 0, 1, 3, 0);
    chk("en_wrap_state", 64'(STATE), 64'h0);
    chk("en_wrap_wrap", 64'(WRAP), 64'h0);
    chk("en_wrap_led", 64'(LED), 64'h0);
    cyc(1, 0, 0, 1, 15);
    ft = 0;
    for (int t = 1; t <= 40 && ft == 0; t++) begin
      cyc(1, 0, 1, 1, 15);
      if (STEP != 0) ft = t;
    end
    chk("dwell15_first_advance", 64'(ft), 64'd16);

    // Asynchronous reset mid-pass at step 7.
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) cyc(1, 0, 1, 0, 0);
    chk("pre_reset_step", 64'(STEP), 64'd7);
    RESET = 1'b1;
    #1;
    chk("async_rst_led", 64'(LED), 64'h0);
    chk("async_rst_step", 64'(STEP), 64'h0);
    chk("async_rst_state", 64'(STATE), 64'h0);
    chk("async_rst_wrap", 64'(WRAP), 64'h0);
    model_reset();
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    cyc(1, 0, 1, 0, 0);
    chk("post_rst_entry_state", 64'(STATE), 64'h1);
    chk("post_rst_entry_step", 64'(STEP), 64'h0);

    // Randomized traffic with occasional asynchronous resets.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      int dw;
      dw = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 2));
      cyc($urandom_range(0, 15) != 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)), dw);
      if ($urandom_range(0, 299) == 0) begin
        RESET = 1'b1;
        #1;
        model_reset();
        compare_all();
        RESET = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
